// File: rtl/interface_pkg.sv
// Shared AHB-Lite encodings, the line-wrap mask and the master FSM state set
// for the I-cache refill bus master.
package interface_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } TRANS_TYPES;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    WRAP4  = 3'b010
  } BURST_TYPES;

  localparam logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0;
  localparam logic [3:0]  WORD_OFFSET_MASK    = 4'hC;
  localparam logic [3:0]  BEAT_BYTES          = 4'd4;

  // Legacy state codes, kept so existing waveform decoders still line up.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DATA  = 2'd3;

  typedef enum logic [1:0] {
    IDLE_S  = ST_IDLE,
    ADDR_S  = ST_ADDR,
    BURST_S = ST_BURST,
    DATA_S  = ST_DATA
  } MASTER_STATES;

  // Next word offset inside a 16-byte line; the 4-bit add wraps 0xC -> 0x0.
  function automatic logic [3:0] wrap4_next(input logic [3:0] off);
    return off + BEAT_BYTES;
  endfunction

endpackage

// File: rtl/wrap4_addr_gen.sv
// WRAP4 address generator: given the line base and the current word offset,
// produces the next wrapped offset and the full next beat address.
module wrap4_addr_gen
  import interface_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_base,
  input  logic [3:0]        i_offset,
  output logic [3:0]        o_next_offset,
  output logic [ADDR_W-1:0] o_next_addr
);

  logic [3:0] w_next_offset;

  assign w_next_offset = wrap4_next(i_offset);
  assign o_next_offset = w_next_offset;
  // Base is line aligned, so OR-ing in the offset equals adding it.
  assign o_next_addr   = i_base | ADDR_W'(w_next_offset);

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite read master for I-cache refills: SINGLE and WRAP4 word reads,
// address phase overlapped with the previous data phase, one response per
// completed beat tagged with its line offset.
// Optional macro AHB_MASTER_HRESP_EN adds hresp/rsp_err and two-cycle ERROR
// handling that cancels the remaining beats.
module ahb_burst_master
  import interface_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wrap4,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic              hwrite,
  output logic [2:0]        hsize,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata,
`ifdef AHB_MASTER_HRESP_EN
  input  logic              hresp,
  output logic              rsp_err,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_offset,
  output logic              rsp_last
);

  MASTER_STATES      r_state;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_offset;
  logic [2:0]        r_beats;
  logic [2:0]        r_issue_cnt;
  logic [2:0]        r_data_cnt;
  logic [3:0]        r_pend_off;
  logic [ADDR_W-1:0] r_haddr;
  TRANS_TYPES        r_htrans;
  BURST_TYPES        r_hburst;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [3:0]        r_rsp_offset;
  logic              r_rsp_last;

  logic [ADDR_W-1:0] w_base;
  logic [3:0]        w_offset;
  logic              w_accept;
  logic              w_in_data;
  logic              w_data_done;
  logic [3:0]        w_next_offset;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_err_hold;
  logic              w_err_done;

  assign w_base    = req_addr & ADDR_W'(WRAP4_BOUNDARY_MASK);
  assign w_offset  = req_addr[3:0] & WORD_OFFSET_MASK;
  assign req_ready = (r_state == IDLE_S) & ~rst;
  assign w_accept  = req_valid & req_ready;

  // A data phase is outstanding in BURST (previous beat) and DATA (last beat).
  assign w_in_data   = (r_state == BURST_S) | (r_state == DATA_S);
  assign w_data_done = hready & w_in_data;

`ifdef AHB_MASTER_HRESP_EN
  logic r_rsp_err;
  assign w_err_hold = hresp & ~hready & w_in_data;
  assign w_err_done = hresp &  hready & w_in_data;
  assign rsp_err    = r_rsp_err;
`else
  assign w_err_hold = 1'b0;
  assign w_err_done = 1'b0;
`endif

  wrap4_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_wrap4_addr_gen (
    .i_base        (r_base),
    .i_offset      (r_offset),
    .o_next_offset (w_next_offset),
    .o_next_addr   (w_next_addr)
  );

  // Request capture, address-phase sequencing and FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE_S;
      r_base      <= '0;
      r_offset    <= '0;
      r_beats     <= '0;
      r_issue_cnt <= '0;
      r_pend_off  <= '0;
      r_haddr     <= '0;
      r_htrans    <= IDLE;
      r_hburst    <= SINGLE;
    end else begin
      case (r_state)
        IDLE_S: begin
          if (w_accept) begin
            r_base      <= w_base;
            r_offset    <= w_offset;
            r_beats     <= req_wrap4 ? 3'd4 : 3'd1;
            r_issue_cnt <= '0;
            r_haddr     <= w_base + ADDR_W'(w_offset);
            r_htrans    <= NONSEQ;
            r_hburst    <= req_wrap4 ? WRAP4 : SINGLE;
            r_state     <= ADDR_S;
          end
        end
        ADDR_S: begin
          if (hready) begin
            r_issue_cnt <= r_issue_cnt + 3'd1;
            r_pend_off  <= r_haddr[3:0];
            if (r_beats == 3'd1) begin
              r_htrans <= IDLE;
              r_state  <= DATA_S;
            end else begin
              r_offset <= w_next_offset;
              r_haddr  <= w_next_addr;
              r_htrans <= SEQ;
              r_state  <= BURST_S;
            end
          end
        end
        BURST_S: begin
          if (w_err_done) begin
            r_htrans <= IDLE;
            r_state  <= IDLE_S;
          end else if (w_err_hold) begin
            r_htrans <= IDLE;
          end else if (hready) begin
            r_issue_cnt <= r_issue_cnt + 3'd1;
            r_pend_off  <= r_haddr[3:0];
            if (r_issue_cnt + 3'd1 == r_beats) begin
              r_htrans <= IDLE;
              r_state  <= DATA_S;
            end else begin
              r_offset <= w_next_offset;
              r_haddr  <= w_next_addr;
            end
          end
        end
        DATA_S: begin
          if (w_err_done || hready) begin
            r_htrans <= IDLE;
            r_state  <= IDLE_S;
          end else if (w_err_hold) begin
            r_htrans <= IDLE;
          end
        end
        default: r_state <= IDLE_S;
      endcase
    end
  end

  // Response path: one registered pulse per completed data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_cnt   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_offset <= '0;
      r_rsp_last   <= 1'b0;
    end else begin
      r_rsp_valid <= w_data_done;
      r_rsp_last  <= w_data_done & (w_err_done | (r_data_cnt + 3'd1 == r_beats));
      if (w_accept) begin
        r_data_cnt <= '0;
      end else if (w_data_done) begin
        r_data_cnt <= r_data_cnt + 3'd1;
      end
      if (w_data_done) begin
        r_rsp_data   <= hrdata;
        r_rsp_offset <= r_pend_off;
      end
    end
  end

`ifdef AHB_MASTER_HRESP_EN
  // Error flag accompanies the terminating response of a failed request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_err_done;
    end
  end
`endif

  assign haddr      = r_haddr;
  assign htrans     = r_htrans;
  assign hburst     = r_hburst;
  assign hwrite     = 1'b0;
  assign hsize      = 3'b010;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_offset = r_rsp_offset;
  assign rsp_last   = r_rsp_last;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: SINGLE, WRAP4, wait states,
// back-to-back requests, mid-burst reset and (with AHB_MASTER_HRESP_EN)
// slave ERROR termination.
module tb_ahb_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wrap4;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hrdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_offset;
  logic        rsp_last;
`ifdef AHB_MASTER_HRESP_EN
  logic        hresp;
  logic        rsp_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] t2_addr [4];
  logic [3:0]  t2_off  [4];
  logic [31:0] t3_addr [7];
  logic [1:0]  t3_trans[7];
  int          pulses;
  int          lastk;

  ahb_burst_master #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wrap4  (req_wrap4),
    .haddr      (haddr),
    .htrans     (htrans),
    .hburst     (hburst),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hready     (hready),
    .hrdata     (hrdata),
`ifdef AHB_MASTER_HRESP_EN
    .hresp      (hresp),
    .rsp_err    (rsp_err),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_offset (rsp_offset),
    .rsp_last   (rsp_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    t2_addr  = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
    t2_off   = '{4'h8, 4'hC, 4'h0, 4'h4};
    t3_addr  = '{32'h3000, 32'h3004, 32'h3004, 32'h3004, 32'h3008, 32'h300C, 32'h300C};
    t3_trans = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wrap4 = 1'b0;
    hready    = 1'b1;
    hrdata    = '0;
`ifdef AHB_MASTER_HRESP_EN
    hresp     = 1'b0;
`endif

    // Reset values
    step();
    step();
    chk("rst req_ready", req_ready, 0);
    chk("rst htrans", htrans, 0);
    chk("rst haddr", haddr, 0);
    chk("rst hburst", hburst, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_offset", rsp_offset, 0);
    chk("rst rsp_last", rsp_last, 0);
    rst = 1'b0;
    step();
    chk("post-rst req_ready", req_ready, 1);

    // SINGLE read of 0x1006
    req_valid = 1'b1; req_addr = 32'h1006; req_wrap4 = 1'b0; hrdata = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0;
    chk("s htrans T+1", htrans, 2);
    chk("s haddr T+1", haddr, 32'h1004);
    chk("s hburst T+1", hburst, 0);
    chk("s hwrite", hwrite, 0);
    chk("s hsize", hsize, 2);
    chk("s req_ready busy", req_ready, 0);
    step();
    chk("s htrans T+2", htrans, 0);
    chk("s rsp_valid T+2", rsp_valid, 0);
    step();
    chk("s rsp_valid T+3", rsp_valid, 1);
    chk("s rsp_data", rsp_data, 32'hDEAD_BEEF);
    chk("s rsp_offset", rsp_offset, 4);
    chk("s rsp_last", rsp_last, 1);
    chk("s req_ready T+3", req_ready, 1);
    step();
    chk("s rsp_valid T+4", rsp_valid, 0);

    // WRAP4 at 0x2008, zero wait states
    req_valid = 1'b1; req_addr = 32'h2008; req_wrap4 = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      hrdata = 32'hA000_0000 + 32'(k);
      if (k <= 4) begin
        chk("w htrans", htrans, (k == 1) ? 2 : 3);
        chk("w haddr", haddr, t2_addr[k-1]);
        chk("w hburst", hburst, 2);
      end else begin
        chk("w htrans idle", htrans, 0);
      end
      chk("w rsp_valid", rsp_valid, (k >= 3) ? 1 : 0);
      if (k >= 3) begin
        chk("w rsp_data", rsp_data, 32'hA000_0000 + 32'(k - 1));
        chk("w rsp_offset", rsp_offset, t2_off[k-3]);
        chk("w rsp_last", rsp_last, (k == 6) ? 1 : 0);
      end
      chk("w req_ready", req_ready, (k == 6) ? 1 : 0);
      step();
    end
    chk("w rsp_valid after", rsp_valid, 0);

    // WRAP4 at 0x3000 with two wait states on the second address phase
    req_valid = 1'b1; req_addr = 32'h3000; req_wrap4 = 1'b1;
    step();
    req_valid = 1'b0;
    pulses = 0;
    lastk  = 0;
    for (int k = 1; k <= 9; k++) begin
      hready = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      if (k <= 7) begin
        chk("ws haddr", haddr, t3_addr[k-1]);
        chk("ws htrans", htrans, t3_trans[k-1]);
      end
      if (k >= 2 && k <= 4) chk("ws stall no rsp", rsp_valid, 0);
      if (rsp_valid) pulses++;
      if (rsp_last) lastk = k;
      step();
    end
    hready = 1'b1;
    chk("ws rsp pulses", pulses, 4);
    chk("ws last cycle", lastk, 8);

    // Back-to-back: SINGLE 0x10 then WRAP4 0x40 with req_valid held
    req_valid = 1'b1; req_addr = 32'h10; req_wrap4 = 1'b0;
    step();
    req_addr = 32'h40; req_wrap4 = 1'b1;
    chk("b2b ready T+1", req_ready, 0);
    step();
    chk("b2b htrans T+2", htrans, 0);
    chk("b2b ready T+2", req_ready, 0);
    step();
    chk("b2b first last", rsp_last, 1);
    chk("b2b ready T+3", req_ready, 1);
    step();
    chk("b2b 2nd htrans", htrans, 2);
    chk("b2b 2nd haddr", haddr, 32'h40);
    chk("b2b 2nd hburst", hburst, 2);
    for (int k = 4; k <= 9; k++) begin
      chk("b2b ready busy", req_ready, (k == 9) ? 1 : 0);
      if (k == 9) begin
        chk("b2b second last", rsp_last, 1);
        chk("b2b last offset", rsp_offset, 4'hC);
        req_valid = 1'b0;
      end
      step();
    end
    chk("b2b no extra accept", htrans, 0);

    // Reset pulse during beat 3 of a WRAP4
    req_valid = 1'b1; req_addr = 32'h50; req_wrap4 = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("rb pre-reset rsp", rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("rb htrans", htrans, 0);
    chk("rb rsp_valid", rsp_valid, 0);
    chk("rb req_ready", req_ready, 0);
    chk("rb haddr", haddr, 0);
    step();
    rst = 1'b0;
    step();
    chk("rb ready after", req_ready, 1);
    chk("rb no rsp_last", rsp_last, 0);
    req_valid = 1'b1; req_addr = 32'h64; req_wrap4 = 1'b0; hrdata = 32'h1234_5678;
    step();
    req_valid = 1'b0;
    chk("rb new htrans", htrans, 2);
    chk("rb new haddr", haddr, 32'h64);
    step();
    step();
    chk("rb new rsp", rsp_valid, 1);
    chk("rb new data", rsp_data, 32'h1234_5678);
    chk("rb new last", rsp_last, 1);

`ifdef AHB_MASTER_HRESP_EN
    // Two-cycle ERROR on beat 2 of a WRAP4
    step();
    req_valid = 1'b1; req_addr = 32'h70; req_wrap4 = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("er haddr T+2", haddr, 32'h74);
    step();
    chk("er beat1 rsp", rsp_valid, 1);
    chk("er beat1 err", rsp_err, 0);
    hresp = 1'b1; hready = 1'b0;
    step();
    chk("er htrans idle", htrans, 0);
    chk("er no rsp", rsp_valid, 0);
    hready = 1'b1;
    step();
    hresp = 1'b0;
    chk("er rsp_valid", rsp_valid, 1);
    chk("er rsp_err", rsp_err, 1);
    chk("er rsp_last", rsp_last, 1);
    chk("er req_ready", req_ready, 1);
    step();
    chk("er htrans after", htrans, 0);
    chk("er rsp_valid after", rsp_valid, 0);
    chk("er rsp_err after", rsp_err, 0);
    step();
    chk("er no more beats", rsp_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
# ahb_burst_master

AHB-Lite read initiator that issues SINGLE and WRAP4 word reads on behalf of the I-cache refill logic. It is the bus-side counterpart of the cache's slave transfer handler. It accepts one request at a time and drives the address phase (haddr/htrans/hburst), overlapping it with the data phase. It returns each beat to the refill logic with its line offset.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; one word per beat.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master idle; request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored (forced 0).
- req_wrap4  in  1  1 = WRAP4 line fill, 0 = SINGLE.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  AHB transfer type (IDLE/NONSEQ/SEQ; BUSY never driven).
- hburst  out  3  AHB burst type (SINGLE or WRAP4).
- hwrite  out  1  tied 0.
- hsize  out  3  tied 3'b010 (word).
- hready  in  1  AHB ready; completes the current address and data phases.
- hrdata  in  DATA_W  AHB read data.
- rsp_valid  out  1  one beat returned.
- rsp_data  out  DATA_W  beat data.
- rsp_offset  out  4  byte offset within the 16-byte line (haddr[3:0] of that beat).
- rsp_last  out  1  final beat of the request.

## Operation
- States: IDLE, ADDR (NONSEQ address phase, no data phase pending), BURST (SEQ address phase overlapping the previous beat's data phase), DATA (final data phase, htrans=IDLE).
- IDLE:
  - req_ready=1, htrans=IDLE.
  - On accept, register base = req_addr & 32'hFFFF_FFF0, offset = req_addr[3:0] & 4'hC, beats = req_wrap4 ? 4 : 1. Then go to ADDR.
- ADDR:
  - Drive htrans=NONSEQ, haddr=base+offset, hburst per request.
  - On hready: for a SINGLE request go to DATA; for WRAP4 go to BURST.
- BURST:
  - Drive htrans=SEQ, hburst=WRAP4, haddr=base | next_offset.
  - next_offset = (offset+4) mod 16, 4-bit wrap: 0x1008 -> 0x100C -> 0x1000 -> 0x1004.
  - Each hready completes one data phase and one address phase.
  - After the 4th address phase is accepted, go to DATA.
- DATA: htrans=IDLE, haddr/hburst hold their last values. On hready, go to IDLE.
- Counters:
  - issue_cnt (0..4) counts accepted address phases.
  - data_cnt (0..4) counts completed data phases.
  - A per-beat offset FIFO of depth 1 (register) carries the address-phase offset to the data phase.
- While hready=0, all AHB outputs hold and the counters do not advance.

## Timing
- Reset values: req_ready=0 while rst is high and 1 after release; htrans=IDLE; haddr=0; hburst=SINGLE; rsp_valid=0, rsp_data=0, rsp_offset=0, rsp_last=0; state IDLE.
- AHB outputs are registered.
- Accept at cycle T with zero wait states:
  - NONSEQ at T+1, first data phase at T+2.
  - rsp_valid at T+3, registered one cycle after the data phase completes.
- WRAP4 with zero wait states:
  - Address phases at T+1..T+4, data phases at T+2..T+5, responses at T+3..T+6.
  - rsp_last at T+6.
  - req_ready returns at T+6, so the next NONSEQ can appear at T+7.
- SINGLE: rsp_last at T+3; req_ready at T+3.
- Wait states: each hready=0 cycle stretches the current phase by one cycle. rsp_valid pulses once per completed data phase only.
- Reset asserted mid-burst: all outputs go immediately to their reset values; the in-flight request is dropped and no rsp_last is issued.
- req_valid outside IDLE is ignored (req_ready=0).

## Configuration
- AHB_MASTER_HRESP_EN defined:
  - Adds input hresp (1 bit, 1=ERROR) and output rsp_err (1 bit, reset 0).
  - First error cycle (hresp=1, hready=0): the master drives htrans=IDLE next cycle, cancelling remaining beats.
  - Second error cycle (hresp=1, hready=1): rsp_valid=1, rsp_err=1, rsp_last=1 on the next cycle; then IDLE.
- Undefined: neither port exists, and slave errors are not visible to the master.

## Structure
- interface_pkg holds:
  - TRANS_TYPES (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - BURST_TYPES (SINGLE=3'b000, WRAP4=3'b010).
  - WRAP4_BOUNDARY_MASK (32'hFFFF_FFF0).
  - MASTER_STATES enum (IDLE_S, ADDR_S, BURST_S, DATA_S).
- One sub-module, wrap4_addr_gen (base, offset -> next wrapped offset). Everything else stays in ahb_burst_master.

## Test plan
- SINGLE read of 0x0000_1006, zero wait states, hrdata=0xDEAD_BEEF:
  - Bus shows haddr=0x1004, NONSEQ, hburst=SINGLE.
  - At T+3: rsp_valid, rsp_data=0xDEAD_BEEF, rsp_offset=4, rsp_last=1.
- WRAP4 read at 0x0000_2008, zero wait states:
  - haddr sequence 0x2008, 0x200C, 0x2000, 0x2004; htrans NONSEQ, SEQ, SEQ, SEQ, then IDLE.
  - rsp_offset sequence 8, C, 0, 4; rsp_last on the 4th beat only.
- WRAP4 at 0x3000 with hready=0 for 2 cycles during beat 2: haddr=0x3004 is held for 3 cycles, exactly 4 rsp_valid pulses are seen, and the burst ends 2 cycles later than with zero wait states.
- Back-to-back requests, SINGLE 0x10 then WRAP4 0x40, req_valid held high: the second NONSEQ appears one cycle after the first rsp_last, and nothing is accepted while busy.
- Reset pulse during beat 3 of a WRAP4: htrans=IDLE, rsp_valid=0 and req_ready=0 in the same cycle; a new request is accepted after reset is released.
- With AHB_MASTER_HRESP_EN, two-cycle ERROR on beat 2 of a WRAP4: htrans goes to IDLE after the first error cycle, rsp_err=1 with rsp_last=1, and no further beats are issued.
